// File: rtl/univ_shift_engine_if.sv
// Bus interface for univ_shift_engine: control, load data, serial inputs and
// register/status outputs. The lost flag exists only when UNIV_SHIFT_LOST_EN
// is defined.
interface univ_shift_engine_if #(
  parameter int N   = 8,
  parameter int SHW = 4
);
  logic           en;
  logic           load;
  logic [N-1:0]   I;
  logic           start;
  logic [2:0]     mode;
  logic [SHW-1:0] amt;
  logic           MSB_in;
  logic           LSB_in;
  logic [N-1:0]   Q;
  logic           busy;
  logic           done;
`ifdef UNIV_SHIFT_LOST_EN
  logic           lost;
`endif

  // Driver side (datapath / testbench)
  modport master (
    output en, load, I, start, mode, amt, MSB_in, LSB_in,
`ifdef UNIV_SHIFT_LOST_EN
    input  lost,
`endif
    input  Q, busy, done
  );

  // Shift engine side
  modport slave (
    input  en, load, I, start, mode, amt, MSB_in, LSB_in,
`ifdef UNIV_SHIFT_LOST_EN
    output lost,
`endif
    output Q, busy, done
  );
endinterface

// File: rtl/univ_shift_engine.sv
// Universal N-bit shift engine: parallel load, then a counted sequence of
// single-bit shift/rotate/arithmetic steps under a start/busy/done handshake.
// Optional sticky shifted-out-one flag: define UNIV_SHIFT_LOST_EN.
module univ_shift_engine #(
  parameter int N   = 8,
  parameter int SHW = 4
) (
  input  logic clk,
  input  logic reset,
  univ_shift_engine_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [2:0]     mode_q, mode_d;
  logic [N-1:0]   q_q, q_d;
  logic           done_q, done_d;
  logic           lost_q, lost_d;

  // One step of the latched operation; unused codes hold the register.
  function automatic logic [N-1:0] step_fn(input logic [2:0] m, input logic [N-1:0] q,
                                           input logic msb, input logic lsb);
    case (m)
      3'b001:  step_fn = {msb, q[N-1:1]};
      3'b010:  step_fn = {q[N-2:0], lsb};
      3'b011:  step_fn = {q[0], q[N-1:1]};
      3'b100:  step_fn = {q[N-2:0], q[N-1]};
      3'b101:  step_fn = {q[N-1], q[N-1:1]};
      default: step_fn = q;
    endcase
  endfunction

  // Bit discarded by a non-rotating shift; rotates and holds lose nothing.
  function automatic logic lost_fn(input logic [2:0] m, input logic [N-1:0] q);
    case (m)
      3'b001, 3'b101: lost_fn = q[0];
      3'b010:         lost_fn = q[N-1];
      default:        lost_fn = 1'b0;
    endcase
  endfunction

  // Next-state: idle load/start arbitration and one step per enabled run cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    done_d  = 1'b0;
    lost_d  = lost_q;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            q_d    = bus.I;
            lost_d = 1'b0;
          end else if (bus.start) begin
            lost_d = 1'b0;
            if (bus.amt != '0) begin
              mode_d  = bus.mode;
              cnt_d   = bus.amt;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          q_d    = step_fn(mode_q, q_q, bus.MSB_in, bus.LSB_in);
          lost_d = lost_q | lost_fn(mode_q, q_q);
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; done is a single-cycle pulse even while en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
      q_q     <= '0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
`ifdef UNIV_SHIFT_LOST_EN
  assign bus.lost = lost_q;
`else
  logic unused_lost;
  assign unused_lost = lost_q;
`endif

endmodule
